// File: rtl/lo_synth_spi_ctrl.sv
// 3-wire serial controller for the LO synthesizer: turns a software-register
// start edge into an MSB-first SCLK/SDATA frame followed by a latch-enable pulse.
module lo_synth_spi_ctrl #(
  parameter int unsigned NBITS   = 24,
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned SLE_CYC = 4
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] lo_data,
  input  logic [31:0] lo_ctrl,
  output logic        lo_sclk,
  output logic        lo_sdata,
  output logic        lo_sle,
  output logic        lo_busy,
  output logic [31:0] lo_status
);

  localparam int unsigned CNT_MAX = (CLK_DIV > SLE_CYC) ? CLK_DIV : SLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_e;

  state_e             state_q, state_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        done_cnt_q, done_cnt_d;
  logic               sclk_q, sclk_d;
  logic               sdata_q, sdata_d;
  logic               sle_q, sle_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               ctrl_prev_q;
  logic               start;
  logic [NBITS-1:0]   shift_next;
  logic               unused_ok;

  // Upper data bits and control bits other than start are don't-care.
  assign unused_ok = ^{lo_data, lo_ctrl[31:1]};

  // Edge-detect history runs through reset so a level held across reset cannot start a frame.
  always_ff @(posedge user_clk) begin
    ctrl_prev_q <= lo_ctrl[0];
  end

  assign start      = lo_ctrl[0] & ~ctrl_prev_q & ~user_rst;
  assign shift_next = shift_q << 1;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      done_cnt_q <= '0;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      sle_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      done_cnt_q <= done_cnt_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      sle_q      <= sle_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    done_cnt_d = done_cnt_q;
    sclk_d     = sclk_q;
    sdata_d    = sdata_q;
    sle_d      = sle_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        sle_d  = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          shift_d   = lo_data[NBITS-1:0];
          sdata_d   = lo_data[NBITS-1];
          bit_cnt_d = BIT_W'(NBITS);
          cnt_d     = '0;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_cnt_q == BIT_W'(1)) begin
            sdata_d = 1'b0;
            sle_d   = 1'b1;
            state_d = LATCH;
          end else begin
            shift_d   = shift_next;
            sdata_d   = shift_next[NBITS-1];
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            state_d   = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt_q == CNT_W'(SLE_CYC - 1)) begin
          cnt_d      = '0;
          sle_d      = 1'b0;
          busy_d     = 1'b0;
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A start edge outside IDLE is dropped but remembered as an overrun.
    if (start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  assign lo_sclk   = sclk_q;
  assign lo_sdata  = sdata_q;
  assign lo_sle    = sle_q;
  assign lo_busy   = busy_q;
  assign lo_status = {overrun_q, busy_q, 14'b0, done_cnt_q};

endmodule

// File: tb/tb_lo_synth_spi_ctrl.sv
// Directed self-checking bench for lo_synth_spi_ctrl (CLK_DIV=2, NBITS=24, SLE_CYC=4).
module tb_lo_synth_spi_ctrl;

  localparam int unsigned FRAME_CYC = 2 * 2 * 24 + 4;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic [31:0] lo_data  = 32'h0;
  logic [31:0] lo_ctrl  = 32'h0;
  logic        lo_sclk;
  logic        lo_sdata;
  logic        lo_sle;
  logic        lo_busy;
  logic [31:0] lo_status;

  int          n_checks = 0;
  int          n_fail   = 0;

  // Bus monitor state, sampled on the falling edge
  logic [31:0] rx          = 32'h0;
  int          rx_bits     = 0;
  int          busy_cyc    = 0;
  int          sle_cyc     = 0;
  int          sle_pulses  = 0;
  logic        sclk_prev   = 1'b0;
  logic        sle_prev    = 1'b0;

  lo_synth_spi_ctrl #(
    .NBITS  (24),
    .CLK_DIV(2),
    .SLE_CYC(4)
  ) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .lo_data  (lo_data),
    .lo_ctrl  (lo_ctrl),
    .lo_sclk  (lo_sclk),
    .lo_sdata (lo_sdata),
    .lo_sle   (lo_sle),
    .lo_busy  (lo_busy),
    .lo_status(lo_status)
  );

  always #5 user_clk = ~user_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge user_clk);
    if (lo_sclk && !sclk_prev) begin
      rx = {rx[30:0], lo_sdata};
      rx_bits++;
    end
    sclk_prev = lo_sclk;
    if (lo_busy) busy_cyc++;
    if (lo_sle) sle_cyc++;
    if (lo_sle && !sle_prev) sle_pulses++;
    sle_prev = lo_sle;
  endtask

  task automatic clr_mon();
    rx         = 32'h0;
    rx_bits    = 0;
    busy_cyc   = 0;
    sle_cyc    = 0;
    sle_pulses = 0;
  endtask

  task automatic start_frame(input logic [31:0] data);
    lo_data = data;
    lo_ctrl = 32'h0;
    tick();
    clr_mon();
    lo_ctrl = 32'h1;
    tick();
    lo_ctrl = 32'h0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (lo_busy && k < 1000) begin
      tick();
      k++;
    end
    check_eq("idle_timeout", 32'(lo_busy), 32'h0);
  endtask

  task automatic wait_bits(input int n);
    int k = 0;
    while (rx_bits < n && k < 1000) begin
      tick();
      k++;
    end
    check_eq("bits_timeout", 32'(rx_bits >= n), 32'h1);
  endtask

  task automatic do_reset();
    user_rst = 1'b1;
    tick();
    tick();
    user_rst = 1'b0;
    tick();
  endtask

  initial begin
    // Reset values
    do_reset();
    check_eq("rst_sclk", 32'(lo_sclk), 32'h0);
    check_eq("rst_sdata", 32'(lo_sdata), 32'h0);
    check_eq("rst_sle", 32'(lo_sle), 32'h0);
    check_eq("rst_busy", 32'(lo_busy), 32'h0);
    check_eq("rst_status", lo_status, 32'h0);

    // Single frame
    start_frame(32'hFF_A5F00F);
    check_eq("t1_busy_rise", 32'(lo_busy), 32'h1);
    check_eq("t1_first_bit", 32'(lo_sdata), 32'h1);
    wait_idle();
    check_eq("t1_busy_cyc", 32'(busy_cyc), 32'(FRAME_CYC));
    check_eq("t1_nbits", 32'(rx_bits), 32'd24);
    check_eq("t1_data", rx & 32'h00FF_FFFF, 32'h00A5F00F);
    check_eq("t1_sle_cyc", 32'(sle_cyc), 32'd4);
    check_eq("t1_sle_pulses", 32'(sle_pulses), 32'd1);
    check_eq("t1_status", lo_status, 32'h0000_0001);

    // Overrun: second edge mid-frame is dropped and flagged
    start_frame(32'h005A5A5A);
    begin
      int k = 0;
      while (busy_cyc < 40 && k < 200) begin
        tick();
        k++;
      end
    end
    lo_ctrl = 32'h1;
    tick();
    lo_ctrl = 32'h0;
    check_eq("t2_ovr_set", 32'(lo_status[31]), 32'h1);
    wait_idle();
    check_eq("t2_busy_cyc", 32'(busy_cyc), 32'(FRAME_CYC));
    check_eq("t2_data", rx & 32'h00FF_FFFF, 32'h005A5A5A);
    check_eq("t2_status_end", lo_status, 32'h8000_0002);
    start_frame(32'h000F0F0F);
    check_eq("t2_ovr_clr", lo_status, 32'h4000_0002);
    wait_idle();
    check_eq("t2_status_2", lo_status, 32'h0000_0003);

    // Level hold: one frame only
    do_reset();
    lo_data = 32'h00123456;
    clr_mon();
    lo_ctrl = 32'h1;
    for (int i = 0; i < 500; i++) tick();
    check_eq("t3_busy_cyc", 32'(busy_cyc), 32'(FRAME_CYC));
    check_eq("t3_sle_pulses", 32'(sle_pulses), 32'd1);
    check_eq("t3_status", lo_status, 32'h0000_0001);

    // Reset released with start bit already high
    do_reset();
    clr_mon();
    for (int i = 0; i < 20; i++) tick();
    check_eq("t4_no_frame", 32'(busy_cyc), 32'h0);
    check_eq("t4_status", lo_status, 32'h0);
    lo_ctrl = 32'h0;
    tick();
    lo_ctrl = 32'h1;
    tick();
    check_eq("t4_busy", 32'(lo_busy), 32'h1);
    lo_ctrl = 32'h0;
    wait_idle();
    check_eq("t4_status_end", lo_status, 32'h0000_0001);

    // Reset mid-frame at bit 10
    start_frame(32'h00FFFFFF);
    wait_bits(10);
    user_rst = 1'b1;
    tick();
    check_eq("t5_sclk", 32'(lo_sclk), 32'h0);
    check_eq("t5_sdata", 32'(lo_sdata), 32'h0);
    check_eq("t5_sle", 32'(lo_sle), 32'h0);
    check_eq("t5_busy", 32'(lo_busy), 32'h0);
    check_eq("t5_status", lo_status, 32'h0);
    user_rst = 1'b0;
    for (int i = 0; i < 150; i++) tick();
    check_eq("t5_no_sle", 32'(sle_pulses), 32'h0);
    start_frame(32'h00C3A55A);
    wait_idle();
    check_eq("t5_nbits", 32'(rx_bits), 32'd24);
    check_eq("t5_data", rx & 32'h00FF_FFFF, 32'h00C3A55A);
    check_eq("t5_status_end", lo_status, 32'h0000_0001);

    // Data changed mid-frame does not affect the frame in flight
    start_frame(32'h00FFFFFF);
    wait_bits(5);
    lo_data = 32'h0;
    wait_idle();
    check_eq("t6_nbits", 32'(rx_bits), 32'd24);
    check_eq("t6_data", rx & 32'h00FF_FFFF, 32'h00FFFFFF);
    check_eq("t6_status", lo_status, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lo_synth_spi_ctrl.md
Name: lo_synth_spi_ctrl

Overview:
- Consumes the 32-bit software-register words written by the PPC (LO data word, LO control word) in the user_clk domain.
- Serialises the data word onto the LO synthesizer's 3-wire interface (clock, data, latch-enable).
- Sits directly downstream of the LO_SLE/LO data ppc2simulink registers.
- Returns a status word for a simulink2ppc readback register.

Parameters:
- NBITS, 24: number of bits shifted per transaction, taken from lo_data[NBITS-1:0] MSB-first; legal range 1..32.
- CLK_DIV, 8: user_clk cycles per SCLK half-period; legal range ≥1.
- SLE_CYC, 4: user_clk cycles that lo_sle is held high after the last bit; legal range ≥1.

Ports:
- user_clk  in  1  sole clock; all logic is in this domain.
- user_rst  in  1  synchronous, active-high reset.
- lo_data  in  32  data word from the LO data software register.
- lo_ctrl  in  32  control word; bit0 = start (rising-edge triggered); other bits ignored.
- lo_sclk  out  1  synthesizer serial clock.
- lo_sdata  out  1  synthesizer serial data.
- lo_sle  out  1  synthesizer latch enable, active high.
- lo_busy  out  1  transaction in progress.
- lo_status  out  32  {overrun, busy, 14'b0, done_cnt[15:0]}.

Behaviour:
- Clock and reset: one clock, user_clk. Reset user_rst is synchronous and active-high.
- Output reset values: lo_sclk=0, lo_sdata=0, lo_sle=0, lo_busy=0, overrun=0, done_cnt=0, state=IDLE. All outputs are registered.
- Start edge detect:
  - ctrl_prev <= lo_ctrl[0] every cycle, including while user_rst=1. A start bit already high at reset release therefore does not trigger.
  - start = lo_ctrl[0] & ~ctrl_prev & ~user_rst.
- Data capture: when a start is accepted, lo_data[NBITS-1:0] is captured into shift_reg in that same cycle. Later changes to lo_data do not affect the frame in flight.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - sclk=0, sle=0, busy=0.
  - On start: shift_reg <= captured word, lo_sdata <= bit NBITS-1, bit_cnt <= NBITS, div_cnt <= 0, busy <= 1, state <= SHIFT_LO.
  - lo_busy and the first data bit appear one cycle after the start edge.
- SHIFT_LO:
  - sclk=0 for CLK_DIV cycles (data setup), then state <= SHIFT_HI and sclk <= 1.
- SHIFT_HI:
  - sclk=1 for CLK_DIV cycles. The synthesizer samples on the rising edge.
  - At the end of the half-period: if bit_cnt==1, state <= LATCH, sclk <= 0, sdata <= 0, sle <= 1.
  - Otherwise: shift left, sdata <= next bit, bit_cnt--, state <= SHIFT_LO, sclk <= 0.
- LATCH:
  - sle=1 for SLE_CYC cycles, then sle <= 0, busy <= 0, done_cnt++, state <= IDLE.
- Frame length: lo_busy stays high for exactly 2*CLK_DIV*NBITS + SLE_CYC cycles.
- Back-to-back frames: a new start is accepted on the first cycle in IDLE after a frame completes.
- done_cnt: 16-bit counter; wraps 0xFFFF -> 0x0000 without a flag.
- Start edge while busy: ignored (the frame in flight is unaffected) and overrun <= 1. overrun is sticky and is cleared only by the next accepted start or by reset.
- Start edge and frame completion in the same cycle: state is still LATCH, so the start is ignored and overrun is set.
- Reset mid-frame: on the next edge all outputs return to reset values; the partial frame is abandoned (sle is never pulsed); done_cnt is cleared.
- NBITS < 32: lo_data[31:NBITS] is ignored.

Test Plan:
- Single frame (CLK_DIV=2, NBITS=24, SLE_CYC=4): lo_data=0x00A5F00F, lo_ctrl[0] 0->1.
  - Required: busy high for 100 cycles.
  - Bits sampled on the 24 sclk rising edges = 0xA5F00F MSB-first.
  - sle high for 4 cycles after the last sclk falling edge.
  - done_cnt=1 and lo_status=0x00000001 afterwards.
- Overrun: second 0->1 on lo_ctrl[0] at cycle 40 of a frame.
  - Required: the frame completes unchanged; lo_status[31]=1 at end.
  - A later accepted start clears bit31 one cycle after the edge.
- Level hold: lo_ctrl[0] held at 1 for 500 cycles.
  - Required: exactly one frame; done_cnt=1.
- Reset with start bit already high: user_rst released while lo_ctrl[0]=1.
  - Required: no frame; busy stays 0 until the bit goes 0 then 1.
- Reset mid-frame: user_rst pulsed at bit 10.
  - Required: on the next edge sclk=sdata=sle=busy=0; sle never pulses; done_cnt=0.
  - A subsequent start sends a complete 24-bit frame.
- Data change mid-frame: lo_data changed from 0xFFFFFF to 0x000000 at bit 5.
  - Required: all 24 shifted bits are 1.
